// File: rtl/request_conditioner_pkg.sv
// request_conditioner_pkg
//   Definitions shared by the request conditioner front end:
//   - phase codes 0..3, using the same encoding as the intersection controller states
//   - default debounce length (DEBOUNCE_CYCLES_DEFAULT) at the 1 kHz system clock
//   - bit positions of the six conditioned inputs inside the internal request vector
//   - phase_clear_mask(): decodes a served phase into the requests it retires
package request_conditioner_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20;
  localparam int unsigned NUM_INPUTS              = 6;

  typedef enum logic [1:0] {
    PHASE_SS_STRAIGHT = 2'd0,
    PHASE_SS_TURN     = 2'd1,
    PHASE_CS_STRAIGHT = 2'd2,
    PHASE_CS_TURN     = 2'd3
  } phase_e;

  localparam int unsigned IDX_SS_PED      = 0;
  localparam int unsigned IDX_CS_PED      = 1;
  localparam int unsigned IDX_SS_STRAIGHT = 2;
  localparam int unsigned IDX_SS_TURN     = 3;
  localparam int unsigned IDX_CS_STRAIGHT = 4;
  localparam int unsigned IDX_CS_TURN     = 5;

  // Pedestrian crossings are served together with the straight phase of
  // their own street.
  function automatic logic [NUM_INPUTS-1:0] phase_clear_mask(input phase_e phase);
    logic [NUM_INPUTS-1:0] mask;
    mask = '0;
    unique case (phase)
      PHASE_SS_STRAIGHT: begin
        mask[IDX_SS_STRAIGHT] = 1'b1;
        mask[IDX_SS_PED]      = 1'b1;
      end
      PHASE_SS_TURN:     mask[IDX_SS_TURN] = 1'b1;
      PHASE_CS_STRAIGHT: begin
        mask[IDX_CS_STRAIGHT] = 1'b1;
        mask[IDX_CS_PED]      = 1'b1;
      end
      PHASE_CS_TURN:     mask[IDX_CS_TURN] = 1'b1;
      default:           mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/request_conditioner_input_debouncer.sv
// input_debouncer
//   Two-flop synchroniser followed by a run-length debouncer for one raw
//   button or loop sensor.
//   Ports:
//     clk        in   system clock
//     reset      in   asynchronous, active-high reset
//     raw        in   raw input, asynchronous to clk
//     stable     out  debounced level; follows sync2 only after it has differed
//                     for DEBOUNCE_CYCLES consecutive clocks
//     rise_pulse out  one-cycle high while stable has just risen
module input_debouncer
  import request_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise_pulse
);

  localparam int unsigned   CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable_d;
  logic [CW-1:0] count;

  // Flipping on count==LAST is the same as "incremented count reaches
  // DEBOUNCE_CYCLES", so the counter never holds that value and never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      count    <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == LAST) begin
        stable <= sync2;
        count  <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  assign rise_pulse = stable & ~stable_d;

endmodule

// File: rtl/request_conditioner.sv
// request_conditioner
//   Front end for the intersection controller: debounces the two pedestrian
//   buttons and four car sensors and holds each press/arrival as a sticky
//   request until the controller reports the matching phase served.
//   Ports:
//     clk, reset                       1 kHz clock, async active-high reset
//     *_raw (6)                        raw buttons / loop sensors
//     served_valid, served_phase[1:0]  served-phase pulse from the controller
//     *_request (6)                    latched requests
//     any_request                      OR of the six requests
module request_conditioner
  import request_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       straight_street_pedestrian_button_raw,
  input  logic       cross_street_pedestrian_button_raw,
  input  logic       straight_street_straight_lane_car_sensor_raw,
  input  logic       straight_street_turn_lane_car_sensor_raw,
  input  logic       cross_street_straight_lane_car_sensor_raw,
  input  logic       cross_street_turn_lane_car_sensor_raw,
  input  logic       served_valid,
  input  logic [1:0] served_phase,
  output logic       straight_street_pedestrian_request,
  output logic       cross_street_pedestrian_request,
  output logic       straight_street_straight_lane_car_request,
  output logic       straight_street_turn_lane_car_request,
  output logic       cross_street_straight_lane_car_request,
  output logic       cross_street_turn_lane_car_request,
  output logic       any_request
);

  logic [NUM_INPUTS-1:0] raw_vec;
  logic [NUM_INPUTS-1:0] rise_vec;
  logic [NUM_INPUTS-1:0] stable_unused;
  logic [NUM_INPUTS-1:0] clear_vec;
  logic [NUM_INPUTS-1:0] request;

  always_comb begin
    raw_vec                  = '0;
    raw_vec[IDX_SS_PED]      = straight_street_pedestrian_button_raw;
    raw_vec[IDX_CS_PED]      = cross_street_pedestrian_button_raw;
    raw_vec[IDX_SS_STRAIGHT] = straight_street_straight_lane_car_sensor_raw;
    raw_vec[IDX_SS_TURN]     = straight_street_turn_lane_car_sensor_raw;
    raw_vec[IDX_CS_STRAIGHT] = cross_street_straight_lane_car_sensor_raw;
    raw_vec[IDX_CS_TURN]     = cross_street_turn_lane_car_sensor_raw;
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw_vec[i]),
      .stable    (stable_unused[i]),
      .rise_pulse(rise_vec[i])
    );
  end

  always_comb begin
    clear_vec = '0;
    if (served_valid) begin
      clear_vec = phase_clear_mask(phase_e'(served_phase));
    end
  end

  // Set is OR-ed in after the clear so a simultaneous set and clear leaves
  // the request high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      request <= '0;
    end else begin
      request <= (request & ~clear_vec) | rise_vec;
    end
  end

  assign straight_street_pedestrian_request        = request[IDX_SS_PED];
  assign cross_street_pedestrian_request           = request[IDX_CS_PED];
  assign straight_street_straight_lane_car_request = request[IDX_SS_STRAIGHT];
  assign straight_street_turn_lane_car_request     = request[IDX_SS_TURN];
  assign cross_street_straight_lane_car_request    = request[IDX_CS_STRAIGHT];
  assign cross_street_turn_lane_car_request        = request[IDX_CS_TURN];
  assign any_request                               = |request;

endmodule

// File: tb/tb_request_conditioner.sv
// tb_request_conditioner
//   Directed scenarios plus randomized raw/served traffic for request_conditioner,
//   checked every cycle against a behavioural model of the debounce and
//   request rules, with literal expectations at the key latency points.
//   Bit order of raw/req vectors: 0 ss ped, 1 cs ped, 2 ss straight,
//   3 ss turn, 4 cs straight, 5 cs turn.
module tb_request_conditioner;

  localparam int D = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] raw;
  logic       served_valid;
  logic [1:0] served_phase;
  logic [5:0] req_o;
  logic       any_request;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  request_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk                                         (clk),
    .reset                                       (reset),
    .straight_street_pedestrian_button_raw       (raw[0]),
    .cross_street_pedestrian_button_raw          (raw[1]),
    .straight_street_straight_lane_car_sensor_raw(raw[2]),
    .straight_street_turn_lane_car_sensor_raw    (raw[3]),
    .cross_street_straight_lane_car_sensor_raw   (raw[4]),
    .cross_street_turn_lane_car_sensor_raw       (raw[5]),
    .served_valid                                (served_valid),
    .served_phase                                (served_phase),
    .straight_street_pedestrian_request          (req_o[0]),
    .cross_street_pedestrian_request             (req_o[1]),
    .straight_street_straight_lane_car_request   (req_o[2]),
    .straight_street_turn_lane_car_request       (req_o[3]),
    .cross_street_straight_lane_car_request      (req_o[4]),
    .cross_street_turn_lane_car_request          (req_o[5]),
    .any_request                                 (any_request)
  );

  // ---------------- behavioural model ----------------
  // Requests retired by each served phase.
  function automatic logic [5:0] mask_of(input logic [1:0] p);
    case (p)
      2'd0:    return 6'b000101;
      2'd1:    return 6'b001000;
      2'd2:    return 6'b010010;
      default: return 6'b100000;
    endcase
  endfunction

  // m_seen1/m_seen2: raw as sampled one and two edges ago (what the
  // debouncer sees after synchronisation). A level is accepted once the
  // synchronised value has disagreed with the accepted level for D
  // consecutive edges; a request appears one edge after acceptance of a 1.
  logic [5:0] m_seen1, m_seen2, m_level, m_level_prev, m_req;
  int         m_run [6];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_seen1      <= '0;
      m_seen2      <= '0;
      m_level      <= '0;
      m_level_prev <= '0;
      m_req        <= '0;
      for (int i = 0; i < 6; i++) m_run[i] <= 0;
    end else begin : model_step
      logic [5:0] clr;
      logic [5:0] nlevel;
      int         nrun;
      clr    = served_valid ? mask_of(served_phase) : 6'b0;
      nlevel = m_level;
      for (int i = 0; i < 6; i++) begin
        if (m_seen2[i] == m_level[i]) nrun = 0;
        else nrun = m_run[i] + 1;
        if (nrun >= D) begin
          nlevel[i] = m_seen2[i];
          nrun      = 0;
        end
        m_run[i] <= nrun;
      end
      m_req        <= (m_req & ~clr) | (m_level & ~m_level_prev);
      m_level_prev <= m_level;
      m_level      <= nlevel;
      m_seen2      <= m_seen1;
      m_seen1      <= raw;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      compared = compared + 2;
      if (req_o !== m_req) begin
        mismatched = mismatched + 1;
        if (mismatched < 30)
          $display("FAIL model_req t=%0t got=%b expected=%b", $time, req_o, m_req);
      end
      if (any_request !== (|m_req)) begin
        mismatched = mismatched + 1;
        if (mismatched < 30)
          $display("FAIL model_any t=%0t got=%b expected=%b", $time, any_request, |m_req);
      end
    end
  end

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    compared = compared + 1;
    if (got !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, exp);
    end
  endtask

  // Advance n rising edges, then move 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [1:0] p);
    served_valid = 1'b1;
    served_phase = p;
    step(1);
    served_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset with every raw input high
    reset        = 1'b1;
    raw          = 6'b111111;
    served_valid = 1'b0;
    served_phase = 2'd0;
    #13;
    chk("t1_in_reset", req_o, 6'b0);
    step(2);
    reset = 1'b0;                     // edge 0 was the last edge in reset
    step(22);
    chk("t1_edge22", req_o, 6'b0);
    chk("t1_edge22_any", {5'b0, any_request}, 6'b0);
    step(1);
    chk("t1_edge23", req_o, 6'b111111);
    chk("t1_edge23_any", {5'b0, any_request}, 6'b1);

    // held inputs must not re-set after clearing
    for (int p = 0; p < 4; p++) serve(2'(p));
    chk("t1_cleared_all", req_o, 6'b0);
    step(30);
    chk("t1_held_no_reset", req_o, 6'b0);

    // 2. glitch reject then exact-length accept on ss ped
    raw = 6'b0;
    step(30);
    raw[0] = 1'b1;
    step(19);
    raw[0] = 1'b0;
    step(30);
    chk("t2_glitch19", req_o, 6'b0);
    raw[0] = 1'b1;
    step(20);
    raw[0] = 1'b0;
    step(2);
    chk("t2_edge22", req_o, 6'b0);
    step(1);
    chk("t2_edge23", req_o, 6'b000001);
    serve(2'd0);
    chk("t2_cleared", req_o, 6'b0);

    // 3. bounce on cs turn, then a steady high
    step(30);
    for (int t = 0; t < 20; t++) begin
      raw[5] = ~raw[5];
      step(5);
    end
    chk("t3_bounce_none", req_o, 6'b0);
    raw[5] = 1'b1;
    step(22);
    chk("t3_edge22", req_o, 6'b0);
    step(1);
    chk("t3_edge23", req_o, 6'b100000);

    // 4. clear map
    raw = 6'b111111;
    step(25);
    chk("t4_all_set", req_o, 6'b111111);
    serve(2'd2);
    chk("t4_phase2", req_o, 6'b101101);
    chk("t4_phase2_any", {5'b0, any_request}, 6'b1);
    serve(2'd0);
    chk("t4_phase0", req_o, 6'b101000);
    serve(2'd1);
    chk("t4_phase1", req_o, 6'b100000);
    serve(2'd3);
    chk("t4_phase3", req_o, 6'b0);
    chk("t4_any_zero", {5'b0, any_request}, 6'b0);

    // 5. set/clear collision on ss turn
    raw[3] = 1'b0;
    step(30);
    raw[3] = 1'b1;
    step(22);
    chk("t5_before", req_o, 6'b0);
    serve(2'd1);                      // clear sampled on edge 23 with the set
    chk("t5_collision", req_o, 6'b001000);

    // 6. async reset mid-count
    raw[0] = 1'b0;
    step(30);
    raw[0] = 1'b1;
    step(17);                         // debounce count now 15
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_req", req_o, 6'b0);
    chk("t6_async_any", {5'b0, any_request}, 6'b0);
    step(2);
    reset = 1'b0;
    step(22);
    chk("t6_edge22", req_o, 6'b0);
    step(1);
    chk("t6_edge23", req_o, 6'b111111);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 6; i++)
        if ($urandom_range(0, 29) == 0) raw[i] = ~raw[i];
      served_valid = ($urandom_range(0, 7) == 0);
      served_phase = 2'($urandom_range(0, 3));
      step(1);
    end

    served_valid = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
